// File: rtl/ppu_render_pkg.sv
// Shared types and constants for the tile-row renderer: FSM states,
// ppu_ctrl2 / sprite attribute bit positions and the palette index helper.
package ppu_render_pkg;

    typedef enum logic [3:0] {
        IDLE,
        BG_NT,
        BG_LO,
        BG_HI,
        BG_AT,
        SPR_LO,
        SPR_HI,
        SPR_NEXT,
        WRITE,
        DONE
    } state_t;

    localparam int CTRL_BG_LEFT  = 1;
    localparam int CTRL_SPR_LEFT = 2;
    localparam int CTRL_BG_EN    = 3;
    localparam int CTRL_SPR_EN   = 4;

    localparam int ATTR_BEHIND = 5;
    localparam int ATTR_HFLIP  = 6;
    localparam int ATTR_VFLIP  = 7;

    function automatic logic [3:0] pal_index(input logic [1:0] pal, input logic [1:0] val);
        return {pal, val};
    endfunction

endpackage

// File: rtl/ppu_tile_row_render_nspr_pixel_mux.sv
// Per-pixel BG/sprite priority resolution and palette lookup.
module ppu_pixel_mux
    import ppu_render_pkg::*;
#(
    parameter int PAL_W = 8
) (
    input  logic [1:0]          bg_val,
    input  logic [1:0]          bg_pal,
    input  logic                spr_opaque,
    input  logic [1:0]          spr_val,
    input  logic [1:0]          spr_pal,
    input  logic                spr_behind,
    input  logic [16*PAL_W-1:0] bg_colors,
    input  logic [16*PAL_W-1:0] spr_colors,
    output logic [PAL_W-1:0]    color
);

    always_comb begin
        color = bg_colors[PAL_W-1:0];
        if (spr_opaque && (!spr_behind || bg_val == 2'b00)) begin
            color = spr_colors[int'(pal_index(spr_pal, spr_val))*PAL_W +: PAL_W];
        end else if (bg_val != 2'b00) begin
            color = bg_colors[int'(pal_index(bg_pal, bg_val))*PAL_W +: PAL_W];
        end
    end

endmodule

// File: rtl/ppu_tile_row_render_nspr.sv
// Renders one 8-pixel tile row: BG fetch, per-slot sprite fetch, pixel write-out.
// Define PPU_SPRITE_FLIP_EN to honour sprite hflip/vflip attribute bits.
module ppu_tile_row_render_nspr
    import ppu_render_pkg::*;
#(
    parameter int NUM_SPRITES = 2,
    parameter int PAL_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [8:0]               curr_row,
    input  logic [8:0]               curr_col,
    output logic [15:0]              vram_addr,
    input  logic [7:0]               vram_data_in,
    input  logic [7:0]               ppu_ctrl2,
    input  logic [16*PAL_W-1:0]      background_colors,
    input  logic [15:0]              background_pattern_base,
    input  logic [15:0]              nametable_ptr,
    input  logic [2:0]               pattern_table_offset,
    input  logic [15:0]              attr_ptr,
    input  logic [1:0]               attr_shift,
    input  logic [16*PAL_W-1:0]      sprite_colors,
    input  logic [15:0]              sprite_pattern_base,
    input  logic [NUM_SPRITES-1:0]   sprite_on_tile,
    input  logic [8*NUM_SPRITES-1:0] sprite_tile_num,
    input  logic [8*NUM_SPRITES-1:0] sprite_row,
    input  logic [8*NUM_SPRITES-1:0] sprite_col,
    input  logic [8*NUM_SPRITES-1:0] sprite_attr,
    output logic [8:0]               vga_ram_row,
    output logic [8:0]               vga_ram_col,
    output logic [PAL_W-1:0]         vga_ram_data,
    output logic                     vga_write_en,
    output logic                     busy,
    output logic                     sprite0_hit
);

    state_t state_q, state_d;
    logic       ph_q, ph_d;
    logic [3:0] idx_q, idx_d;
    logic [2:0] pix_q, pix_d;
    logic       busy_q, busy_d;

    logic [8:0]               row_q, row_d, col_q, col_d;
    logic [7:0]               ctrl_q, ctrl_d;
    logic [16*PAL_W-1:0]      bgc_q, bgc_d, spc_q, spc_d;
    logic [15:0]              bg_base_q, bg_base_d, spr_base_q, spr_base_d, attr_ptr_q, attr_ptr_d;
    logic [2:0]               off_q, off_d;
    logic [1:0]               attr_shift_q, attr_shift_d;
    logic [NUM_SPRITES-1:0]   on_q, on_d;
    logic [8*NUM_SPRITES-1:0] tile_q, tile_d, srow_q, srow_d, scol_q, scol_d, sattr_q, sattr_d;
    logic [8*NUM_SPRITES-1:0] slo_q, slo_d, shi_q, shi_d;
    logic [7:0]               nt_q, nt_d, bg_lo_q, bg_lo_d, bg_hi_q, bg_hi_d, at_q, at_d;

    logic [15:0]      vaddr_q, vaddr_d;
    logic [8:0]       vrow_q, vrow_d, vcol_q, vcol_d;
    logic [PAL_W-1:0] vdata_q, vdata_d;
    logic             vwe_q, vwe_d, hit_q, hit_d;

    // Sprite fetch addressing for the current slot and the next slot to visit.
    logic [3:0]  nxt_slot;
    logic        nxt_on;
    logic [15:0] cur_addr, nxt_addr;

    always_comb begin
        logic [7:0]             a_b;
        logic [2:0]             r;
        logic [15:0]            addr;
        logic [NUM_SPRITES-1:0] on_sh;
        nxt_slot = (state_q == BG_AT) ? 4'd0 : idx_q + 4'd1;
        nxt_on   = 1'b0;
        cur_addr = '0;
        nxt_addr = '0;
        a_b      = '0;
        r        = '0;
        addr     = '0;
        on_sh    = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            a_b = sattr_q[8*i +: 8];
            r   = row_q[2:0] - srow_q[8*i +: 3];
`ifdef PPU_SPRITE_FLIP_EN
            if (a_b[ATTR_VFLIP]) r = 3'd7 - r;
`endif
            addr  = spr_base_q + {4'h0, tile_q[8*i +: 8], 4'h0} + {13'b0, r};
            on_sh = on_q >> i;
            if (idx_q == 4'(i)) cur_addr = addr;
            if (nxt_slot == 4'(i)) begin
                nxt_addr = addr;
                nxt_on   = on_sh[0];
            end
        end
    end

    // Pixel evaluation for pixel pix_q of the row.
    logic signed [9:0] pix_col;
    logic              on_screen, slot0_opaque, spr_opaque, spr_behind;
    logic [1:0]        bg_val, bg_pal, spr_val, spr_pal;
    logic [PAL_W-1:0]  pix_color;

    always_comb begin
        logic              col_ge8, bg_show, spr_show, in_range, opq;
        logic [2:0]        bg_bit, s_bit;
        logic signed [9:0] s_off;
        logic [7:0]        a_b, lo_b, hi_b;
        logic [1:0]        s_val;
        logic [NUM_SPRITES-1:0] on_sh;
        pix_col   = $signed({col_q[8], col_q}) + $signed({7'b0, pix_q});
        on_screen = (pix_col >= 10'sd0) && (pix_col <= 10'sd255)
                    && ($signed(row_q) >= 9'sd0) && ($signed(row_q) <= 9'sd239);
        col_ge8   = pix_col >= 10'sd8;
        bg_show   = ctrl_q[CTRL_BG_EN] && (col_ge8 || ctrl_q[CTRL_BG_LEFT]);
        spr_show  = ctrl_q[CTRL_SPR_EN] && (col_ge8 || ctrl_q[CTRL_SPR_LEFT]);
        bg_bit    = 3'd7 - pix_q;
        bg_val    = bg_show ? {bg_hi_q[bg_bit], bg_lo_q[bg_bit]} : 2'b00;
        bg_pal    = at_q[{attr_shift_q, 1'b0} +: 2];
        spr_opaque   = 1'b0;
        spr_val      = 2'b00;
        spr_pal      = 2'b00;
        spr_behind   = 1'b0;
        slot0_opaque = 1'b0;
        in_range = 1'b0;
        opq      = 1'b0;
        s_bit    = '0;
        s_off    = '0;
        a_b      = '0;
        lo_b     = '0;
        hi_b     = '0;
        s_val    = '0;
        on_sh    = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            a_b      = sattr_q[8*i +: 8];
            lo_b     = slo_q[8*i +: 8];
            hi_b     = shi_q[8*i +: 8];
            on_sh    = on_q >> i;
            s_off    = pix_col - $signed({2'b00, scol_q[8*i +: 8]});
            in_range = (s_off >= 10'sd0) && (s_off <= 10'sd7);
            s_bit    = 3'd7 - s_off[2:0];
`ifdef PPU_SPRITE_FLIP_EN
            if (a_b[ATTR_HFLIP]) s_bit = s_off[2:0];
`endif
            s_val = {hi_b[s_bit], lo_b[s_bit]};
            opq   = on_sh[0] && spr_show && in_range && (s_val != 2'b00);
            if (i == 0) slot0_opaque = opq;
            if (opq && !spr_opaque) begin
                spr_opaque = 1'b1;
                spr_val    = s_val;
                spr_pal    = a_b[1:0];
                spr_behind = a_b[ATTR_BEHIND];
            end
        end
    end

    ppu_pixel_mux #(.PAL_W(PAL_W)) u_mux (
        .bg_val     (bg_val),
        .bg_pal     (bg_pal),
        .spr_opaque (spr_opaque),
        .spr_val    (spr_val),
        .spr_pal    (spr_pal),
        .spr_behind (spr_behind),
        .bg_colors  (bgc_q),
        .spr_colors (spc_q),
        .color      (pix_color)
    );

    // Read states present the address in phase 0; data is captured in phase 1
    // and the next address is loaded on that same transition.
    always_comb begin
        logic advance;
        advance      = 1'b0;
        state_d      = state_q;
        ph_d         = ph_q;
        idx_d        = idx_q;
        pix_d        = pix_q;
        busy_d       = busy_q;
        row_d        = row_q;
        col_d        = col_q;
        ctrl_d       = ctrl_q;
        bgc_d        = bgc_q;
        spc_d        = spc_q;
        bg_base_d    = bg_base_q;
        spr_base_d   = spr_base_q;
        attr_ptr_d   = attr_ptr_q;
        off_d        = off_q;
        attr_shift_d = attr_shift_q;
        on_d         = on_q;
        tile_d       = tile_q;
        srow_d       = srow_q;
        scol_d       = scol_q;
        sattr_d      = sattr_q;
        slo_d        = slo_q;
        shi_d        = shi_q;
        nt_d         = nt_q;
        bg_lo_d      = bg_lo_q;
        bg_hi_d      = bg_hi_q;
        at_d         = at_q;
        vaddr_d      = vaddr_q;
        vrow_d       = vrow_q;
        vcol_d       = vcol_q;
        vdata_d      = vdata_q;
        vwe_d        = 1'b0;
        hit_d        = hit_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d        = curr_row;
                    col_d        = curr_col;
                    ctrl_d       = ppu_ctrl2;
                    bgc_d        = background_colors;
                    spc_d        = sprite_colors;
                    bg_base_d    = background_pattern_base;
                    spr_base_d   = sprite_pattern_base;
                    attr_ptr_d   = attr_ptr;
                    off_d        = pattern_table_offset;
                    attr_shift_d = attr_shift;
                    on_d         = sprite_on_tile;
                    tile_d       = sprite_tile_num;
                    srow_d       = sprite_row;
                    scol_d       = sprite_col;
                    sattr_d      = sprite_attr;
                    hit_d        = 1'b0;
                    busy_d       = 1'b1;
                    ph_d         = 1'b0;
                    vaddr_d      = nametable_ptr;
                    state_d      = BG_NT;
                end
            end
            BG_NT: begin
                if (ph_q) begin
                    nt_d    = vram_data_in;
                    vaddr_d = bg_base_q + {4'h0, vram_data_in, 4'h0} + {13'b0, off_q};
                    ph_d    = 1'b0;
                    state_d = BG_LO;
                end else ph_d = 1'b1;
            end
            BG_LO: begin
                if (ph_q) begin
                    bg_lo_d = vram_data_in;
                    vaddr_d = bg_base_q + {4'h0, nt_q, 4'h0} + {13'b0, off_q} + 16'd8;
                    ph_d    = 1'b0;
                    state_d = BG_HI;
                end else ph_d = 1'b1;
            end
            BG_HI: begin
                if (ph_q) begin
                    bg_hi_d = vram_data_in;
                    vaddr_d = attr_ptr_q;
                    ph_d    = 1'b0;
                    state_d = BG_AT;
                end else ph_d = 1'b1;
            end
            BG_AT: begin
                if (ph_q) begin
                    at_d    = vram_data_in;
                    advance = 1'b1;
                end else ph_d = 1'b1;
            end
            SPR_LO: begin
                if (ph_q) begin
                    for (int unsigned i = 0; i < NUM_SPRITES; i++)
                        if (idx_q == 4'(i)) slo_d[8*i +: 8] = vram_data_in;
                    vaddr_d = cur_addr + 16'd8;
                    ph_d    = 1'b0;
                    state_d = SPR_HI;
                end else ph_d = 1'b1;
            end
            SPR_HI: begin
                if (ph_q) begin
                    for (int unsigned i = 0; i < NUM_SPRITES; i++)
                        if (idx_q == 4'(i)) shi_d[8*i +: 8] = vram_data_in;
                    advance = 1'b1;
                end else ph_d = 1'b1;
            end
            SPR_NEXT: advance = 1'b1;
            WRITE: begin
                if (on_screen) begin
                    vwe_d   = 1'b1;
                    vrow_d  = row_q;
                    vcol_d  = pix_col[8:0];
                    vdata_d = pix_color;
                    if (pix_col != 10'sd255 && slot0_opaque && bg_val != 2'b00) hit_d = 1'b1;
                end
                pix_d = pix_q + 3'd1;
                if (pix_q == 3'd7) state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (advance) begin
            idx_d = nxt_slot;
            ph_d  = 1'b0;
            if (nxt_slot == 4'(NUM_SPRITES)) begin
                pix_d   = '0;
                state_d = WRITE;
            end else if (nxt_on) begin
                vaddr_d = nxt_addr;
                state_d = SPR_LO;
            end else begin
                state_d = SPR_NEXT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            ph_q         <= 1'b0;
            idx_q        <= '0;
            pix_q        <= '0;
            busy_q       <= 1'b0;
            row_q        <= '0;
            col_q        <= '0;
            ctrl_q       <= '0;
            bgc_q        <= '0;
            spc_q        <= '0;
            bg_base_q    <= '0;
            spr_base_q   <= '0;
            attr_ptr_q   <= '0;
            off_q        <= '0;
            attr_shift_q <= '0;
            on_q         <= '0;
            tile_q       <= '0;
            srow_q       <= '0;
            scol_q       <= '0;
            sattr_q      <= '0;
            slo_q        <= '0;
            shi_q        <= '0;
            nt_q         <= '0;
            bg_lo_q      <= '0;
            bg_hi_q      <= '0;
            at_q         <= '0;
            vaddr_q      <= '0;
            vrow_q       <= '0;
            vcol_q       <= '0;
            vdata_q      <= '0;
            vwe_q        <= 1'b0;
            hit_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            idx_q        <= idx_d;
            pix_q        <= pix_d;
            busy_q       <= busy_d;
            row_q        <= row_d;
            col_q        <= col_d;
            ctrl_q       <= ctrl_d;
            bgc_q        <= bgc_d;
            spc_q        <= spc_d;
            bg_base_q    <= bg_base_d;
            spr_base_q   <= spr_base_d;
            attr_ptr_q   <= attr_ptr_d;
            off_q        <= off_d;
            attr_shift_q <= attr_shift_d;
            on_q         <= on_d;
            tile_q       <= tile_d;
            srow_q       <= srow_d;
            scol_q       <= scol_d;
            sattr_q      <= sattr_d;
            slo_q        <= slo_d;
            shi_q        <= shi_d;
            nt_q         <= nt_d;
            bg_lo_q      <= bg_lo_d;
            bg_hi_q      <= bg_hi_d;
            at_q         <= at_d;
            vaddr_q      <= vaddr_d;
            vrow_q       <= vrow_d;
            vcol_q       <= vcol_d;
            vdata_q      <= vdata_d;
            vwe_q        <= vwe_d;
            hit_q        <= hit_d;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{ctrl_q, srow_q, sattr_q, pix_col};

    assign vram_addr    = vaddr_q;
    assign vga_ram_row  = vrow_q;
    assign vga_ram_col  = vcol_q;
    assign vga_ram_data = vdata_q;
    assign vga_write_en = vwe_q;
    assign busy         = busy_q;
    assign sprite0_hit  = hit_q;

endmodule

// File: tb/tb_ppu_tile_row_render_nspr.sv
// Scoreboard bench for ppu_tile_row_render_nspr with directed tile-row scenarios.
module tb_ppu_tile_row_render_nspr;

    localparam int NS = 2;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            start = 1'b0;
    logic [8:0]      curr_row = '0, curr_col = '0;
    logic [15:0]     vram_addr;
    logic [7:0]      vram_data_in = '0;
    logic [7:0]      ppu_ctrl2 = 8'h1E;
    logic [16*PW-1:0] background_colors, sprite_colors;
    logic [15:0]     background_pattern_base = 16'h0000;
    logic [15:0]     nametable_ptr = 16'h2000;
    logic [2:0]      pattern_table_offset = '0;
    logic [15:0]     attr_ptr = 16'h23C0;
    logic [1:0]      attr_shift = '0;
    logic [15:0]     sprite_pattern_base = 16'h1000;
    logic [NS-1:0]   sprite_on_tile = '0;
    logic [8*NS-1:0] sprite_tile_num = '0, sprite_row = '0, sprite_col = '0, sprite_attr = '0;
    logic [8:0]      vga_ram_row, vga_ram_col;
    logic [PW-1:0]   vga_ram_data;
    logic            vga_write_en, busy, sprite0_hit;

    ppu_tile_row_render_nspr #(.NUM_SPRITES(NS), .PAL_W(PW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .curr_row                (curr_row),
        .curr_col                (curr_col),
        .vram_addr               (vram_addr),
        .vram_data_in            (vram_data_in),
        .ppu_ctrl2               (ppu_ctrl2),
        .background_colors       (background_colors),
        .background_pattern_base (background_pattern_base),
        .nametable_ptr           (nametable_ptr),
        .pattern_table_offset    (pattern_table_offset),
        .attr_ptr                (attr_ptr),
        .attr_shift              (attr_shift),
        .sprite_colors           (sprite_colors),
        .sprite_pattern_base     (sprite_pattern_base),
        .sprite_on_tile          (sprite_on_tile),
        .sprite_tile_num         (sprite_tile_num),
        .sprite_row              (sprite_row),
        .sprite_col              (sprite_col),
        .sprite_attr             (sprite_attr),
        .vga_ram_row             (vga_ram_row),
        .vga_ram_col             (vga_ram_col),
        .vga_ram_data            (vga_ram_data),
        .vga_write_en            (vga_write_en),
        .busy                    (busy),
        .sprite0_hit             (sprite0_hit)
    );

    always #5 clk = ~clk;

    logic [7:0] vram [65536];
    always @(posedge clk) vram_data_in <= vram[vram_addr];

    typedef struct packed {
        logic [8:0] row;
        logic [8:0] col;
        logic [7:0] data;
    } px_t;

    px_t exp_q[$];
    px_t mon_e;
    int  checks = 0;
    int  errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (vga_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual col=%0d data=%0h required=no write",
                         vga_ram_col, vga_ram_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_row", 32'(vga_ram_row), 32'(mon_e.row));
                check("wr_col", 32'(vga_ram_col), 32'(mon_e.col));
                check("wr_data", 32'(vga_ram_data), 32'(mon_e.data));
            end
        end
    end

    task automatic expect_px(input logic [8:0] row, input logic [8:0] col, input logic [7:0] data);
        px_t e;
        e.row  = row;
        e.col  = col;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic set_bg(input logic [7:0] tile, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [1:0] shift);
        vram[16'h2000]                       = tile;
        vram[{4'h0, tile, 4'h0}]             = lo;
        vram[{4'h0, tile, 4'h0} + 16'd8]     = hi;
        attr_shift                           = shift;
    endtask

    task automatic set_spr(input int slot, input logic on, input logic [7:0] tile,
                           input logic [7:0] srow, input logic [7:0] scol, input logic [7:0] attr);
        sprite_on_tile[slot]          = on;
        sprite_tile_num[8*slot +: 8]  = tile;
        sprite_row[8*slot +: 8]       = srow;
        sprite_col[8*slot +: 8]       = scol;
        sprite_attr[8*slot +: 8]      = attr;
    endtask

    task automatic render(input string name, input logic [8:0] row, input logic [8:0] col,
                          input int exp_cycles);
        int cyc;
        @(posedge clk); #1;
        curr_row = row;
        curr_col = col;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc   = 0;
        while (busy === 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_cycles"}, 32'(cyc), 32'(exp_cycles));
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int flip_col;
        for (int i = 0; i < 65536; i++) vram[16'(i)] = 8'h00;
        for (int n = 0; n < 16; n++) begin
            background_colors[n*PW +: PW] = 8'(8'h10 + n);
            sprite_colors[n*PW +: PW]     = 8'(8'h40 + n);
        end
        vram[16'h23C0] = 8'hC0;
        vram[16'h1100] = 8'hFF; vram[16'h1108] = 8'h00;
        vram[16'h1110] = 8'hFF; vram[16'h1118] = 8'hFF;
        vram[16'h1120] = 8'h80; vram[16'h1128] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_we", 32'(vga_write_en), 32'd0);
        check("rst_hit", 32'(sprite0_hit), 32'd0);
        check("rst_vaddr", 32'(vram_addr), 32'd0);
        rst = 1'b1;

        // solid BG, palette 3 pixel 3, no sprites
        set_bg(8'h01, 8'hFF, 8'hFF, 2'd3);
        for (int c = 8; c <= 15; c++) expect_px(9'd5, 9'(c), 8'h1F);
        render("bg_solid", 9'd5, 9'd8, 19);
        check("bg_solid_hit", 32'(sprite0_hit), 32'd0);
        render("row240", 9'd240, 9'd8, 19);

        for (int c = 0; c <= 5; c++) expect_px(9'd0, 9'(c), 8'h1F);
        render("col_m2", 9'd0, 9'h1FE, 19);
        for (int c = 252; c <= 255; c++) expect_px(9'd0, 9'(c), 8'h1F);
        render("col_252", 9'd0, 9'd252, 19);

        ppu_ctrl2 = 8'h18;
        for (int c = 0; c <= 7; c++) expect_px(9'd0, 9'(c), 8'h10);
        render("left_mask", 9'd0, 9'd0, 19);
        ppu_ctrl2 = 8'h1E;

        // two front sprites over opaque BG (palette 0 pixel 1)
        set_bg(8'h02, 8'hFF, 8'h00, 2'd0);
        set_spr(0, 1'b1, 8'h10, 8'd0, 8'd3, 8'h01);
        set_spr(1, 1'b1, 8'h11, 8'd0, 8'd14, 8'h02);
        for (int c = 8; c <= 10; c++) expect_px(9'd0, 9'(c), 8'h45);
        for (int c = 11; c <= 13; c++) expect_px(9'd0, 9'(c), 8'h11);
        for (int c = 14; c <= 15; c++) expect_px(9'd0, 9'(c), 8'h4B);
        render("two_spr", 9'd0, 9'd8, 25);
        check("two_spr_hit", 32'(sprite0_hit), 32'd1);

        set_spr(1, 1'b1, 8'h11, 8'd0, 8'd9, 8'h02);
        for (int c = 8; c <= 10; c++) expect_px(9'd0, 9'(c), 8'h45);
        for (int c = 11; c <= 15; c++) expect_px(9'd0, 9'(c), 8'h4B);
        render("overlap", 9'd0, 9'd8, 25);
        check("overlap_hit", 32'(sprite0_hit), 32'd1);

        // behind-BG slot 0 at the right screen edge
        set_bg(8'h01, 8'hFF, 8'hFF, 2'd3);
        set_spr(0, 1'b1, 8'h10, 8'd0, 8'd255, 8'h20);
        set_spr(1, 1'b0, 8'h11, 8'd0, 8'd9, 8'h02);
        for (int c = 248; c <= 255; c++) expect_px(9'd0, 9'(c), 8'h1F);
        render("edge255", 9'd0, 9'd248, 22);
        check("edge255_hit", 32'(sprite0_hit), 32'd0);
        set_spr(0, 1'b1, 8'h10, 8'd0, 8'd254, 8'h20);
        for (int c = 248; c <= 255; c++) expect_px(9'd0, 9'(c), 8'h1F);
        render("edge254", 9'd0, 9'd248, 22);
        check("edge254_hit", 32'(sprite0_hit), 32'd1);

        // hflip single-pixel sprite over transparent BG
`ifdef PPU_SPRITE_FLIP_EN
        flip_col = 15;
`else
        flip_col = 8;
`endif
        set_bg(8'h00, 8'h00, 8'h00, 2'd0);
        set_spr(0, 1'b1, 8'h12, 8'd0, 8'd8, 8'h40);
        for (int c = 8; c <= 15; c++) expect_px(9'd0, 9'(c), (c == flip_col) ? 8'h41 : 8'h10);
        render("hflip", 9'd0, 9'd8, 22);
        check("hflip_hit", 32'(sprite0_hit), 32'd0);
        set_spr(0, 1'b1, 8'h12, 8'd0, 8'd8, 8'h60);
        for (int c = 8; c <= 15; c++) expect_px(9'd0, 9'(c), (c == flip_col) ? 8'h41 : 8'h10);
        render("behind_clear", 9'd0, 9'd8, 22);
        ppu_ctrl2 = 8'h00;
        for (int c = 8; c <= 15; c++) expect_px(9'd0, 9'(c), 8'h10);
        render("ctrl_off", 9'd0, 9'd8, 22);
        ppu_ctrl2 = 8'h1E;

        // reset while slot 0 high plane is being fetched
        set_bg(8'h01, 8'hFF, 8'hFF, 2'd3);
        set_spr(0, 1'b1, 8'h10, 8'd0, 8'd3, 8'h01);
        @(posedge clk); #1;
        curr_row = 9'd0;
        curr_col = 9'd8;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_we", 32'(vga_write_en), 32'd0);
        check("mid_rst_hit", 32'(sprite0_hit), 32'd0);
        check("mid_rst_vaddr", 32'(vram_addr), 32'd0);
        check("mid_rst_row", 32'(vga_ram_row), 32'd0);
        check("mid_rst_col", 32'(vga_ram_col), 32'd0);
        check("mid_rst_data", 32'(vga_ram_data), 32'd0);
        repeat (12) @(posedge clk);
        #1;
        check("held_rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        set_spr(0, 1'b0, 8'h10, 8'd0, 8'd3, 8'h01);
        for (int c = 8; c <= 15; c++) expect_px(9'd5, 9'(c), 8'h1F);
        render("after_rst", 9'd5, 9'd8, 19);
        check("after_rst_hit", 32'(sprite0_hit), 32'd0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
